// File: rtl/darkspi_responder.sv
// SPI mode-0 responder exposing an 8 x 8-bit register bank (regs 0-3 drive OPORT, 4-7 read IPORT).
// Define DARKSPI_IRQ_EN to enable the input-change interrupt on IRQ.
`timescale 1ns/1ps

module darkspi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] OPORT_RESET = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        SPI_SCK,
    input  logic        SPI_MOSI,
    input  logic        SPI_CSN,
    output logic        SPI_MISO,
    output logic        SPI_MISO_OE,
    input  logic [31:0] IPORT,
    output logic [31:0] OPORT,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic                   sck_prev;
    logic                   csn_prev;

    logic sck_s;
    logic mosi_s;
    logic csn_s;
    logic sck_rise;
    logic sck_fall;
    logic csn_rise;
    logic csn_fall;

    state_t      state;
    logic [2:0]  bit_cnt;
    logic [2:0]  addr;
    logic        rw;
    logic [6:0]  shift_in;
    logic [7:0]  shift_out;
    logic        miso;
    logic [31:0] oport;

    logic [7:0]  rx_byte;
    logic [2:0]  next_addr;
    logic        byte_done;
    logic        load_en;
    logic [2:0]  load_addr;

    // NOTE: CSN synchronizer resets to the idle (high) level so reset release never fakes a CSN fall.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            csn_sync  <= '1;
            sck_prev  <= 1'b0;
            csn_prev  <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SPI_SCK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], SPI_CSN};
            sck_prev  <= sck_s;
            csn_prev  <= csn_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign csn_s    = csn_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign csn_rise = csn_s & ~csn_prev;
    assign csn_fall = ~csn_s & csn_prev;

    function automatic logic [7:0] reg_read(input logic [2:0] a, input logic [31:0] o,
                                            input logic [31:0] i);
        logic [31:0] word;
        word = a[2] ? i : o;
        return word[{a[1:0], 3'b000} +: 8];
    endfunction

    always_comb begin
        rx_byte   = {shift_in, mosi_s};
        next_addr = addr + 3'd1;
        byte_done = (state != IDLE) && !csn_s && sck_rise && (bit_cnt == 3'd7);
        load_en   = byte_done && (((state == CMD) && rx_byte[7]) || ((state == DATA) && rw));
        load_addr = (state == CMD) ? rx_byte[2:0] : next_addr;
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            addr      <= 3'd0;
            rw        <= 1'b0;
            shift_in  <= 7'd0;
            shift_out <= 8'd0;
            miso      <= 1'b0;
            oport     <= OPORT_RESET;
        end else if (csn_rise) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
        end else if (csn_fall) begin
            state     <= CMD;
            bit_cnt   <= 3'd0;
            shift_out <= 8'd0;
            miso      <= 1'b0;
        end else if ((state != IDLE) && !csn_s) begin
            if (sck_rise) begin
                shift_in <= rx_byte[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (state == CMD) begin
                        rw    <= rx_byte[7];
                        addr  <= rx_byte[2:0];
                        state <= DATA;
                    end else begin
                        if (!rw && !addr[2])
                            oport[{addr[1:0], 3'b000} +: 8] <= rx_byte;
                        addr <= next_addr;
                    end
                end
                if (load_en)
                    shift_out <= reg_read(load_addr, oport, IPORT);
            end else if (sck_fall) begin
                miso      <= shift_out[7];
                shift_out <= {shift_out[6:0], 1'b0};
            end
        end
    end

    assign SPI_MISO    = miso;
    assign SPI_MISO_OE = ~csn_s;
    assign OPORT       = oport;

`ifdef DARKSPI_IRQ_EN
    logic [31:0] snap;
    logic        irq;
    logic        irq_clear;

    assign irq_clear = load_en && (load_addr == 3'd4);

    // NOTE: snapshot has no async reset; it loads IPORT synchronously while RES is held.
    always_ff @(posedge CLK) begin
        if (RES || irq_clear)
            snap <= IPORT;
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES)
            irq <= 1'b0;
        else if (irq_clear)
            irq <= 1'b0;
        else if (IPORT != snap)
            irq <= 1'b1;
    end

    assign IRQ = irq;
`else
    assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_darkspi_responder.sv
// Self-checking bench for darkspi_responder: directed cases plus randomized SPI transactions
// checked against a byte-level register model.
`timescale 1ns/1ps

module tb_darkspi_responder;

    logic        CLK = 1'b0;
    logic        RES;
    logic        SPI_SCK;
    logic        SPI_MOSI;
    logic        SPI_CSN;
    logic        SPI_MISO;
    logic        SPI_MISO_OE;
    logic [31:0] IPORT;
    logic [31:0] OPORT;
    logic        IRQ;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_oport;
    logic [7:0]  tx_buf [8];
    logic [7:0]  rx_buf [8];
    time         last_change = 0;

    darkspi_responder #(
        .SYNC_STAGES(2),
        .OPORT_RESET(32'h0000_00A5)
    ) dut (
        .CLK        (CLK),
        .RES        (RES),
        .SPI_SCK    (SPI_SCK),
        .SPI_MOSI   (SPI_MOSI),
        .SPI_CSN    (SPI_CSN),
        .SPI_MISO   (SPI_MISO),
        .SPI_MISO_OE(SPI_MISO_OE),
        .IPORT      (IPORT),
        .OPORT      (OPORT),
        .IRQ        (IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic mark();
        last_change = $time;
    endtask

    // Register view of the device: regs 0-3 are OPORT bytes, 4-7 are IPORT bytes.
    function automatic logic [7:0] model_reg(input logic [2:0] a);
        if (a < 3'd4)
            return 8'(exp_oport >> (8 * a));
        else
            return 8'(IPORT >> (8 * (a - 3'd4)));
    endfunction

    // Outputs are compared whenever every input has been stable long enough to pass the synchronizers.
    always begin
        @(posedge CLK);
        #1;
        if (!RES && ($time - last_change) >= 35) begin
            check("oport", OPORT, exp_oport);
            check("miso_oe", SPI_MISO_OE, !SPI_CSN);
`ifndef DARKSPI_IRQ_EN
            check("irq", IRQ, 1'b0);
`endif
        end
    end

    // Mode-0 master: MOSI set while SCK low, MISO sampled just before each rise.
    task automatic send_byte(input logic [7:0] tx, input int nbits, input bit do_write,
                             input logic [2:0] waddr, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            SPI_MOSI = tx[i];
            mark();
            wait_clk(5);
            rx = {rx[6:0], SPI_MISO};
            SPI_SCK = 1'b1;
            mark();
            if (i == 0 && do_write && waddr < 3'd4)
                exp_oport = (exp_oport & ~(32'hFF << (8 * waddr))) | (32'(tx) << (8 * waddr));
            wait_clk(5);
            SPI_SCK = 1'b0;
            mark();
        end
    endtask

    task automatic run_txn(input logic [7:0] cmd, input int nbytes, input int last_bits);
        logic [7:0] rx;
        logic [7:0] exp;
        logic [2:0] a;
        int         bits;
        SPI_CSN = 1'b0;
        mark();
        wait_clk(5);
        send_byte(cmd, 8, 1'b0, 3'd0, rx);
        check("cmd_miso", rx, 8'h00);
        a = cmd[2:0];
        for (int k = 0; k < nbytes; k++) begin
            bits = (k == nbytes - 1) ? last_bits : 8;
            exp  = model_reg(a);
            send_byte(tx_buf[k], bits, !cmd[7], a, rx);
            rx_buf[k] = rx;
            if (bits == 8) begin
                if (cmd[7])
                    check("read_byte", rx, exp);
                a = a + 3'd1;
            end
        end
        wait_clk(5);
        SPI_CSN = 1'b1;
        mark();
        wait_clk(8);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [7:0] rx;
        RES       = 1'b1;
        SPI_SCK   = 1'b0;
        SPI_MOSI  = 1'b0;
        SPI_CSN   = 1'b1;
        IPORT     = 32'h0;
        exp_oport = 32'h0000_00A5;
        mark();
        wait_clk(3);
        check("rst_oport", OPORT, 32'h0000_00A5);
        check("rst_oe", SPI_MISO_OE, 1'b0);
        check("rst_irq", IRQ, 1'b0);
        check("rst_miso", SPI_MISO, 1'b0);
        RES = 1'b0;
        mark();
        wait_clk(5);
        check("post_rst_oport", OPORT, 32'h0000_00A5);
        check("post_rst_oe", SPI_MISO_OE, 1'b0);
        check("post_rst_irq", IRQ, 1'b0);

`ifdef DARKSPI_IRQ_EN
        IPORT = 32'h0000_0001;
        mark();
        @(posedge CLK);
        #1;
        check("irq_set", IRQ, 1'b1);
        wait_clk(1);
        tx_buf[0] = 8'h00;
        run_txn(8'h84, 1, 8);
        check("irq_rd_bit0", rx_buf[0][0], 1'b1);
        check("irq_clear", IRQ, 1'b0);
`endif

        tx_buf[0] = 8'h3C;
        run_txn(8'h00, 1, 8);
        check("single_write", OPORT, 32'h0000_003C);

        tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_buf[2] = 8'h33; tx_buf[3] = 8'h44;
        run_txn(8'h02, 4, 8);
        check("burst_wrap", OPORT, 32'h2211_003C);

        tx_buf[0] = 8'h5A;
        run_txn(8'h03, 1, 8);
        IPORT = 32'hDEAD_BEEF;
        mark();
        tx_buf[0] = 8'h00; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        run_txn(8'h83, 3, 8);
        check("burst_rd0", rx_buf[0], 8'h5A);
        check("burst_rd1", rx_buf[1], 8'hEF);
        check("burst_rd2", rx_buf[2], 8'hBE);

        tx_buf[0] = 8'hFF;
        run_txn(8'h01, 1, 5);
        check("abort_keep", OPORT, 32'h5A11_003C);
        tx_buf[0] = 8'h96;
        run_txn(8'h01, 1, 8);
        check("after_abort", OPORT, 32'h5A11_963C);

        repeat (8) begin
            SPI_MOSI = 1'($urandom);
            SPI_SCK  = 1'b1;
            mark();
            wait_clk(5);
            SPI_SCK = 1'b0;
            mark();
            wait_clk(5);
        end
        check("idle_sck", OPORT, 32'h5A11_963C);

        // Reset in the middle of a write data byte.
        SPI_CSN = 1'b0;
        mark();
        wait_clk(5);
        send_byte(8'h00, 8, 1'b0, 3'd0, rx);
        send_byte(8'hC3, 3, 1'b0, 3'd0, rx);
        RES       = 1'b1;
        exp_oport = 32'h0000_00A5;
        mark();
        wait_clk(2);
        check("res_mid_oport", OPORT, 32'h0000_00A5);
        check("res_mid_oe", SPI_MISO_OE, 1'b0);
        SPI_CSN = 1'b1;
        mark();
        wait_clk(3);
        RES = 1'b0;
        mark();
        wait_clk(5);
        tx_buf[0] = 8'h77;
        run_txn(8'h00, 1, 8);
        check("post_res_write", OPORT, 32'h0000_0077);

        for (int t = 0; t < 40; t++) begin
            logic [7:0] cmd;
            int         n;
            int         last_bits;
            IPORT = $urandom;
            mark();
            cmd       = {1'($urandom), 4'($urandom), 3'($urandom)};
            n         = $urandom_range(1, 6);
            last_bits = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 8;
            for (int k = 0; k < 8; k++)
                tx_buf[k] = 8'($urandom);
            run_txn(cmd, n, last_bits);
        end

        wait_clk(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
